// File: rtl/prio_enc_arb.sv
// Registered MSB-priority encoder with a valid/ready result hold.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating (round-robin) priority.

module prio_enc_lane #(
  parameter int IDX_W = 3,
  parameter int LANE  = 0
) (
  input  logic             vld,
  input  logic [IDX_W-1:0] idx,
  output logic             hit
);
  assign hit = vld && (idx == IDX_W'(LANE));
endmodule

module prio_enc_arb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic             any_req;
  logic             accept;
  logic [IDX_W-1:0] sel_idx;

  assign any_req = |req;
  assign accept  = out_valid & out_ready;
  assign busy    = out_valid;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr;
  logic             found;
  int               c;

  // On an accepting edge the new search must already start below the grant
  // being retired, so the pointer is taken from out_idx, not the stale rr_ptr.
  assign ptr = accept ? out_idx : rr_ptr;

  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      c = int'(ptr) - k;
      if (c < 0) c = c + WIDTH;
      if (!found && req[c]) begin
        sel_idx = IDX_W'(c);
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (req[i]) sel_idx = IDX_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            out_idx   <= sel_idx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            rr_ptr <= out_idx;
`endif
            if (any_req) begin
              out_idx <= sel_idx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // One-hot is decoded from the registered index and gated by valid.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    prio_enc_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
      .vld (out_valid),
      .idx (out_idx),
      .hit (out_onehot[g])
    );
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb: directed steps plus random traffic on an 8-wide
// and a 16-wide instance, checked against a rotate-and-log2 reference model.

module tb_prio_enc_arb;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [7:0]  req8;
  logic [15:0] req16;
  logic        v8, v16, b8, b16;
  logic [2:0]  idx8;
  logic [3:0]  idx16;
  logic [7:0]  oh8;
  logic [15:0] oh16;

  int total;
  int passed;

  int m_valid [2];
  int m_idx   [2];
  int m_ptr   [2];

  prio_enc_arb #(.WIDTH(8), .IDX_W(3)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .out_valid(v8), .out_ready(ready),
    .out_idx(idx8), .out_onehot(oh8), .busy(b8)
  );

  prio_enc_arb #(.WIDTH(16), .IDX_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .out_valid(v16), .out_ready(ready),
    .out_idx(idx16), .out_onehot(oh16), .busy(b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int floor_log2(input logic [63:0] v);
    int n;
    n = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // Rotate so the first candidate (ptr-1) lands on the MSB; then the winner
  // is simply the top set bit, mapped back through the rotation.
  function automatic int pick(input logic [63:0] r, input int w, input int ptr);
    logic [63:0] rot;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    rot = '0;
    for (int p = 0; p < w; p++) rot[p] = r[(p + ptr) % w];
    return (floor_log2(rot) + ptr) % w;
`else
    rot = r;
    return floor_log2(rot) + 0 * ptr;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      m_idx[i]   = 0;
      m_ptr[i]   = 0;
    end
  endtask

  task automatic model_edge(input int n, input logic [63:0] r, input int w, input logic rdy);
    if (m_valid[n] == 0) begin
      if (r != 0) begin
        m_idx[n]   = pick(r, w, m_ptr[n]);
        m_valid[n] = 1;
      end
    end else if (rdy) begin
      m_ptr[n] = m_idx[n];
      if (r != 0) m_idx[n] = pick(r, w, m_ptr[n]);
      else        m_valid[n] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_model(input string tag);
    logic [63:0] e8, e16;
    e8  = (m_valid[0] != 0) ? (64'd1 << m_idx[0]) : 64'd0;
    e16 = (m_valid[1] != 0) ? (64'd1 << m_idx[1]) : 64'd0;
    chk({tag, " v8"},   64'(v8),    64'(m_valid[0]));
    chk({tag, " idx8"}, 64'(idx8),  64'(m_idx[0]));
    chk({tag, " oh8"},  64'(oh8),   e8);
    chk({tag, " b8"},   64'(b8),    64'(m_valid[0]));
    chk({tag, " v16"},  64'(v16),   64'(m_valid[1]));
    chk({tag, " idx16"},64'(idx16), 64'(m_idx[1]));
    chk({tag, " oh16"}, 64'(oh16),  e16);
    chk({tag, " b16"},  64'(b16),   64'(m_valid[1]));
  endtask

  task automatic step(input string tag);
    model_edge(0, 64'(req8), 8, ready);
    model_edge(1, 64'(req16), 16, ready);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  function automatic logic [15:0] rnd_req(input int w);
    logic [15:0] r;
    case ($urandom_range(0, 3))
      0:       r = '0;
      1:       r = 16'd1 << $urandom_range(0, w - 1);
      2:       r = 16'($urandom);
      default: r = 16'($urandom) & 16'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    total  = 0;
    passed = 0;
    model_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    req8  = '0;
    req16 = '0;
    #12;
    chk("rst v8", 64'(v8), 64'd0);
    chk("rst idx8", 64'(idx8), 64'd0);
    chk("rst oh8", 64'(oh8), 64'd0);
    chk("rst b8", 64'(b8), 64'd0);
    rst_n = 1'b1;

    step("idle");
    chk("idle v8", 64'(v8), 64'd0);

    // single request, accepted, then idle with index retained
    req8 = 8'h20; ready = 1'b1;
    step("t1a");
    chk("t1 v8", 64'(v8), 64'd1);
    chk("t1 idx8", 64'(idx8), 64'd5);
    chk("t1 oh8", 64'(oh8), 64'h20);
    req8 = 8'h00;
    step("t1b");
    chk("t1 drop v8", 64'(v8), 64'd0);
    chk("t1 drop oh8", 64'(oh8), 64'd0);
    chk("t1 keep idx8", 64'(idx8), 64'd5);

    // held result ignores req changes until accepted
    req8 = 8'h07; ready = 1'b0;
    step("t2a");
    chk("t2 idx8", 64'(idx8), 64'd2);
    req8 = 8'h80;
    step("t2b");
    chk("t2 hold idx8", 64'(idx8), 64'd2);
    ready = 1'b1;
    step("t2c");
    chk("t2 resel idx8", 64'(idx8), 64'd7);
    chk("t2 resel v8", 64'(v8), 64'd1);
    req8 = 8'h00;
    step("t2d");

    // all-ones held with continuous accept
    req8 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step("t3");
`ifndef PRIO_ENC_ROUND_ROBIN_EN
      chk("t3 idx8", 64'(idx8), 64'd7);
`endif
    end
    req8 = 8'h81;
    for (int i = 0; i < 6; i++) step("t4");
    req8 = 8'h01;
    step("bit0");
    req8 = 8'h00;
    step("t4e");
    step("t4f");

    // async reset while holding idx 3
    req8 = 8'h08; ready = 1'b0;
    step("t5a");
    chk("t5 idx8", 64'(idx8), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5 v8", 64'(v8), 64'd0);
    chk("t5 oh8", 64'(oh8), 64'd0);
    chk("t5 b8", 64'(b8), 64'd0);
    #1;
    rst_n = 1'b1;
    req8 = 8'h00; ready = 1'b1;
    step("t5b");
    chk("t5 idle v8", 64'(v8), 64'd0);

    // 16-wide boundaries
    req16 = 16'h0001;
    step("t6a");
    chk("t6 idx16", 64'(idx16), 64'd0);
    chk("t6 oh16", 64'(oh16), 64'h0001);
    req16 = 16'h8001;
    step("t6b");
    chk("t6 idx16 msb", 64'(idx16), 64'd15);
    req16 = 16'hFFFF;
    step("t6c");
    req16 = 16'h0000;
    step("t6d");
    step("t6e");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req8  = 8'(rnd_req(8));
      req16 = rnd_req(16);
      ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered priority encoder with a valid/ready output handshake.
- Successor to the team's combinational 8-to-3 MSB-priority encoder.
- Scans a WIDTH-bit request vector and registers the winning index plus a one-hot grant.
- Holds the result until a downstream consumer accepts it; sits between request sources and a shared resource.
- Optional round-robin mode for fairness.

Parameters:
- WIDTH, 8, number of request lines; legal range 2..64.
- IDX_W, 3, index width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  WIDTH  level request vector; bit i requests index i
- out_valid  output  1  registered result available
- out_ready  input  1  consumer accepts the result when out_valid=1
- out_idx  output  IDX_W  encoded index of the granted request
- out_onehot  output  WIDTH  one-hot form of out_idx; all zeros when out_valid=0
- busy  output  1  1 in HOLD state (same as out_valid)

Behaviour:
- Reset is asynchronous and active-low, applied immediately on rst_n falling:
  - out_valid=0, out_idx=0, out_onehot=0, busy=0
  - state=IDLE, rr_ptr=0
- States: IDLE, HOLD.
- IDLE:
  - If req != 0: select the winner, register out_idx/out_onehot, set out_valid=1, go to HOLD.
  - Latency from req sampled to out_valid is exactly 1 clock.
  - If req == 0: stay in IDLE; outputs stay at their reset values.
- HOLD:
  - out_idx and out_onehot are frozen; changes on req (including deassertion of the granted bit) are ignored.
  - Accept = out_valid & out_ready.
  - On accept with req != 0 on the same edge: reselect from the current req; stay in HOLD with out_valid=1. Back-to-back throughput is one result per clock.
  - On accept with req == 0: go to IDLE; out_valid=0, out_onehot=0, out_idx keeps its last value.
  - Without accept: stay in HOLD.
- Fixed-priority selection: highest set bit of req wins (MSB priority, as in the existing encoder).
- Width rules:
  - out_idx is zero-extended to IDX_W.
  - out_onehot = 1 << out_idx, computed from the registered idx, never from raw req.
- Boundaries:
  - req all-ones: selects WIDTH-1.
  - req with only bit 0 set: selects 0.
  - out_ready asserted while out_valid=0: ignored.
- Reset mid-HOLD discards the pending result; no accept is reported.

Optional Feature:
Macro: PRIO_ENC_ROUND_ROBIN_EN
- Defined:
  - Add register rr_ptr [IDX_W-1:0], reset 0.
  - Search order starts at rr_ptr-1 and goes downward, wrapping from 0 to WIDTH-1; rr_ptr itself is checked last.
  - On every accept, rr_ptr <= out_idx, so the next selection starts below the last grant.
  - With rr_ptr=0 the first search starts at WIDTH-1, so the first grant after reset matches fixed priority.
  - Wrap arithmetic is modulo WIDTH; for non-power-of-2 WIDTH, the decrement of 0 yields WIDTH-1, never an out-of-range value.
- Undefined:
  - rr_ptr does not exist.
  - Pure fixed MSB priority as described in Behaviour.

Test Plan:
1. Reset, then req=8'h20 for 1 clk, out_ready=1 -> next edge: out_valid=1, out_idx=5, out_onehot=8'h20; following edge with req=0: out_valid=0, out_onehot=0, out_idx=5.
2. req=8'h07, out_ready=0 -> out_idx=2 held; change req to 8'h80 while in HOLD -> out_idx stays 2 until out_ready=1; on that edge with req=8'h80 -> out_idx=7, out_valid stays 1.
3. Fixed mode, req=8'hFF held, out_ready=1 -> out_idx=7 every cycle, out_valid continuously 1.
4. PRIO_ENC_ROUND_ROBIN_EN defined, req=8'hFF held, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7; with req=8'h81 held -> alternates 7,0,7,0.
5. Assert rst_n=0 asynchronously mid-HOLD (out_idx=3) -> out_valid, out_onehot, busy drop to 0 before the next clk edge; after release with req=0 -> remains IDLE.
6. WIDTH=16, IDX_W=4: req=16'h0001 -> out_idx=0, out_onehot=16'h0001; req=16'h8001 -> out_idx=15.
